// File: rtl/pc_seq_pkg.sv
// Shared constants and helpers for the program-counter sequencer.
package pc_seq_pkg;

    localparam logic [1:0] SEL_SEQ = 2'd0;
    localparam logic [1:0] SEL_BR  = 2'd1;
    localparam logic [1:0] SEL_JMP = 2'd2;
    localparam logic [1:0] SEL_RET = 2'd3;

    // Sign-extends the low off_w bits of off to 64 bits, then scales words to bytes.
    function automatic logic [63:0] sext_shl2(input logic [63:0] off, input int unsigned off_w);
        logic [63:0] mask;
        logic [63:0] ext;
        mask = {64{1'b1}} << off_w;
        if (off[6'(off_w - 32'd1)]) begin
            ext = off | mask;
        end else begin
            ext = off & ~mask;
        end
        return ext << 2;
    endfunction

endpackage

// File: rtl/pc_seq_unit_ras.sv
// Circular return-address stack: top pointer plus saturating count, oldest entry overwritten on overflow.
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int B         = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [B-1:0] push_data,
    output logic [B-1:0] top_data,
    output logic         empty,
    output logic         full,
    output logic         err
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(RAS_DEPTH);
    localparam logic [PW:0] CNT_ZERO = {(PW + 1){1'b0}};

    logic [PW-1:0] tp_q, tp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          wr_en_s;
    logic [B-1:0]  mem_q [RAS_DEPTH];

    // Pointer/count/error next state; push and pop never arrive together.
    always_comb begin
        tp_d    = tp_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en_s = 1'b0;
        if (pop) begin
            if (cnt_q == CNT_ZERO) begin
                err_d = 1'b1;
            end else begin
                tp_d  = tp_q - PW'(1);
                cnt_d = cnt_q - (PW + 1)'(1);
            end
        end else if (push) begin
            wr_en_s = 1'b1;
            tp_d    = tp_q + PW'(1);
            if (cnt_q == CNT_FULL) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (PW + 1)'(1);
            end
        end else begin
            tp_d = tp_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tp_q  <= {PW{1'b0}};
            cnt_q <= CNT_ZERO;
            err_q <= 1'b0;
        end else begin
            tp_q  <= tp_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Entry storage carries no reset; contents are meaningless while cnt is 0.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[tp_d] <= push_data;
        end
    end

    assign top_data = mem_q[tp_q];
    assign empty    = (cnt_q == CNT_ZERO);
    assign full     = (cnt_q == CNT_FULL);
    assign err      = err_q;

endmodule

// File: rtl/pc_seq_unit.sv
// PC register with next-PC priority mux (return > jump > branch > sequential) and a return-address stack.
module pc_seq_unit
    import pc_seq_pkg::*;
#(
    parameter int           B         = 32,
    parameter logic [B-1:0] RESET_VEC = {B{1'b0}},
    parameter int           STEP      = 4,
    parameter int           OFF_W     = 16,
    parameter int           RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [OFF_W-1:0] br_off,
    input  logic             jmp,
    input  logic [B-1:0]     jmp_tgt,
    input  logic             call,
    input  logic             ret,
    output logic [B-1:0]     pc_out,
    output logic [B-1:0]     pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    logic [B-1:0] pc_q, pc_d;
    logic [B-1:0] br_tgt_s;
    logic [B-1:0] ras_top_s;
    logic [1:0]   sel_s;
    logic         push_s, pop_s;

    assign pc_plus  = pc_q + B'(STEP);
    assign br_tgt_s = pc_plus + B'(sext_shl2(64'(br_off), OFF_W));

    // Source selection; a return on an empty stack falls back to sequential.
    always_comb begin
        sel_s  = SEL_SEQ;
        push_s = 1'b0;
        pop_s  = 1'b0;
        if (stall) begin
            sel_s = SEL_SEQ;
        end else if (ret) begin
            pop_s = 1'b1;
            if (ras_empty) begin
                sel_s = SEL_SEQ;
            end else begin
                sel_s = SEL_RET;
            end
        end else if (jmp) begin
            sel_s  = SEL_JMP;
            push_s = call;
        end else if (br_taken) begin
            sel_s = SEL_BR;
        end else begin
            sel_s = SEL_SEQ;
        end
    end

    // Next-PC mux.
    always_comb begin
        case (sel_s)
            SEL_RET: pc_d = ras_top_s;
            SEL_JMP: pc_d = jmp_tgt;
            SEL_BR:  pc_d = br_tgt_s;
            SEL_SEQ: pc_d = pc_plus;
            default: pc_d = pc_plus;
        endcase
    end

    // PC register, held while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VEC;
        end else if (!stall) begin
            pc_q <= pc_d;
        end else begin
            pc_q <= pc_q;
        end
    end

    ras_stack #(
        .B         (B),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (pc_plus),
        .top_data  (ras_top_s),
        .empty     (ras_empty),
        .full      (ras_full),
        .err       (ras_err)
    );

    assign pc_out = pc_q;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scenario tasks plus a randomized run against a queue-based model of the PC sequencer.
module tb_pc_seq_unit;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clk, rst, stall, br_taken, jmp, call, ret;
    logic [15:0] br_off;
    logic [31:0] jmp_tgt, pc_out, pc_plus;
    logic        ras_empty, ras_full, ras_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_err;

    pc_seq_unit #(.B(32), .RESET_VEC(RV), .STEP(4), .OFF_W(16), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_off(br_off),
        .jmp(jmp), .jmp_tgt(jmp_tgt), .call(call), .ret(ret),
        .pc_out(pc_out), .pc_plus(pc_plus), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall = 1'b0; br_taken = 1'b0; br_off = 16'h0000; jmp = 1'b0;
        jmp_tgt = 32'h0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = RV;
        m_ras.delete();
        m_err = 1'b0;
    endtask

    // One clock edge: the model applies the architectural rules to the inputs driven now.
    task automatic step();
        int off_i;
        @(posedge clk);
        if (stall) begin
            m_err = 1'b0;
        end else if (ret) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
                m_err = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
                m_err = 1'b1;
            end
        end else if (jmp) begin
            m_err = 1'b0;
            if (call) begin
                if (m_ras.size() == 4) begin
                    void'(m_ras.pop_front());
                    m_err = 1'b1;
                end
                m_ras.push_back(m_pc + 32'd4);
            end
            m_pc = jmp_tgt;
        end else if (br_taken) begin
            off_i = int'($signed(br_off));
            m_pc = m_pc + 32'd4 + 32'(off_i * 4);
            m_err = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
            m_err = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        #4;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic jump_to(input logic [31:0] tgt, input logic lnk);
        idle_inputs(); jmp = 1'b1; call = lnk; jmp_tgt = tgt;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #2;
        vectors++; if (pc_out !== RV) begin miscompares++; $display("FAIL reset_pc: got %h want %h", pc_out, RV); end
        vectors++; if ({ras_empty, ras_full, ras_err} !== 3'b100) begin miscompares++; $display("FAIL reset_flags: got %b want 100", {ras_empty, ras_full, ras_err}); end
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 1; i <= 3; i++) begin
            step();
            vectors++; if (pc_out !== RV + 32'(i * 4)) begin miscompares++; $display("FAIL idle_pc%0d: got %h want %h", i, pc_out, RV + 32'(i * 4)); end
        end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL idle_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_branch();
        jump_to(32'h100, 1'b0);
        br_taken = 1'b1; br_off = 16'hFFFE;
        step();
        vectors++; if (pc_out !== 32'h0FC) begin miscompares++; $display("FAIL br_back: got %h want %h", pc_out, 32'h0FC); end
        jump_to(32'h100, 1'b0);
        br_taken = 1'b1; br_off = 16'h0003;
        step();
        vectors++; if (pc_out !== 32'h110) begin miscompares++; $display("FAIL br_fwd: got %h want %h", pc_out, 32'h110); end
        idle_inputs();
    endtask

    task automatic test_call_ret();
        jump_to(32'h200, 1'b0);
        jump_to(32'h800, 1'b1);
        vectors++; if (pc_out !== 32'h800) begin miscompares++; $display("FAIL call_pc: got %h want %h", pc_out, 32'h800); end
        vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL call_empty: got %b want 0", ras_empty); end
        step(); step();
        ret = 1'b1;
        step();
        idle_inputs();
        vectors++; if (pc_out !== 32'h204) begin miscompares++; $display("FAIL ret_pc: got %h want %h", pc_out, 32'h204); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_nested_overflow();
        logic [31:0] link [5];
        do_reset();
        jump_to(32'h1000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            link[k] = (k == 0) ? 32'h1004 : 32'h2004 + 32'((k - 1) * 32'h100);
            jump_to(32'h2000 + 32'(k * 32'h100), 1'b1);
            vectors++; if (pc_out !== 32'h2000 + 32'(k * 32'h100)) begin miscompares++; $display("FAIL nest_pc%0d: got %h", k, pc_out); end
            vectors++; if (ras_full !== (k >= 3)) begin miscompares++; $display("FAIL nest_full%0d: got %b want %b", k, ras_full, (k >= 3)); end
            vectors++; if (ras_err !== (k == 4)) begin miscompares++; $display("FAIL nest_err%0d: got %b want %b", k, ras_err, (k == 4)); end
        end
        for (int j = 0; j < 4; j++) begin
            ret = 1'b1;
            step();
            vectors++; if (pc_out !== link[4 - j]) begin miscompares++; $display("FAIL unwind%0d: got %h want %h", j, pc_out, link[4 - j]); end
        end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL unwind_empty: got %b want 1", ras_empty); end
        step();
        vectors++; if (pc_out !== 32'h2008) begin miscompares++; $display("FAIL underflow_pc: got %h want %h", pc_out, 32'h2008); end
        vectors++; if (ras_err !== 1'b1) begin miscompares++; $display("FAIL underflow_err: got %b want 1", ras_err); end
        idle_inputs();
        step();
        vectors++; if (ras_err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b want 0", ras_err); end
    endtask

    task automatic test_stall();
        do_reset();
        jump_to(32'h3000, 1'b1);
        stall = 1'b1; jmp = 1'b1; ret = 1'b1; jmp_tgt = 32'h5000;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (pc_out !== 32'h3000) begin miscompares++; $display("FAIL stall_pc%0d: got %h want %h", i, pc_out, 32'h3000); end
            vectors++; if ({ras_empty, ras_err} !== 2'b00) begin miscompares++; $display("FAIL stall_ras%0d: got %b want 00", i, {ras_empty, ras_err}); end
        end
        stall = 1'b0;
        step();
        idle_inputs();
        vectors++; if (pc_out !== RV + 32'd4) begin miscompares++; $display("FAIL ret_wins: got %h want %h", pc_out, RV + 32'd4); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ret_wins_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_wrap_and_async_reset();
        jump_to(32'hFFFF_FFFC, 1'b0);
        vectors++; if (pc_plus !== 32'h0) begin miscompares++; $display("FAIL wrap_plus: got %h want 0", pc_plus); end
        step();
        vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
        jmp = 1'b1; call = 1'b1; jmp_tgt = 32'h900;
        #3;
        rst = 1'b1;
        #1;
        vectors++; if (pc_out !== RV) begin miscompares++; $display("FAIL async_rst_pc: got %h want %h", pc_out, RV); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL async_rst_empty: got %b want 1", ras_empty); end
        #1;
        rst = 1'b0;
        idle_inputs();
        model_reset();
        step();
        vectors++; if ({pc_out, ras_empty} !== {RV + 32'd4, 1'b1}) begin miscompares++; $display("FAIL post_rst: got %h/%b want %h/1", pc_out, ras_empty, RV + 32'd4); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            stall    = ($urandom_range(0, 7) == 0);
            ret      = ($urandom_range(0, 4) == 0);
            jmp      = ($urandom_range(0, 3) == 0);
            call     = 1'($urandom_range(0, 1));
            br_taken = ($urandom_range(0, 2) == 0);
            br_off   = 16'($urandom);
            jmp_tgt  = $urandom & 32'hFFFF_FFFC;
            step();
            vectors++; if (pc_out !== m_pc) begin miscompares++; $display("FAIL rnd_pc@%0d: got %h want %h", n, pc_out, m_pc); end
            vectors++; if (pc_plus !== m_pc + 32'd4) begin miscompares++; $display("FAIL rnd_plus@%0d: got %h want %h", n, pc_plus, m_pc + 32'd4); end
            vectors++; if (ras_empty !== (m_ras.size() == 0)) begin miscompares++; $display("FAIL rnd_empty@%0d: got %b", n, ras_empty); end
            vectors++; if (ras_full !== (m_ras.size() == 4)) begin miscompares++; $display("FAIL rnd_full@%0d: got %b", n, ras_full); end
            vectors++; if (ras_err !== m_err) begin miscompares++; $display("FAIL rnd_err@%0d: got %b want %b", n, ras_err, m_err); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #6;
        test_reset();
        test_branch();
        test_call_ret();
        test_nested_overflow();
        test_stall();
        test_wrap_and_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
Parametrised program-counter sequencer for the MIPS datapath. It holds the PC register and selects the next PC from four sources: sequential increment, PC-relative branch, absolute jump, or return. Jump-and-link pushes the return address onto an internal return-address stack (RAS). It sits at the front of the fetch stage, feeding the instruction-memory address and the link-value path.

Parameters:
B, 32, PC/data width in bits
RESET_VEC, 0, PC value loaded on reset (B bits)
STEP, 4, sequential increment in bytes
OFF_W, 16, branch offset width (word offset, signed)
RAS_DEPTH, 4, number of RAS entries; power of 2, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  hold PC and RAS this cycle
br_taken  in  1  conditional branch resolved taken
br_off  in  OFF_W  signed word offset for branch
jmp  in  1  absolute jump request
jmp_tgt  in  B  absolute jump target address
call  in  1  qualifies jmp as jump-and-link (push)
ret  in  1  return request (pop RAS)
pc_out  out  B  current PC (registered)
pc_plus  out  B  pc_out + STEP (combinational; link value)
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_err  out  1  one-cycle pulse: pop on empty or push on full

Behaviour:
- Reset (async): pc_out=RESET_VEC; RAS count=0, top pointer=0; ras_empty=1; ras_full=0; ras_err=0. RAS entry contents are don't-care.
- Update timing: all inputs are sampled at the rising clk edge. The new pc_out is visible after that edge (1-cycle latency). There is no combinational path from the inputs to pc_out.
- stall=1: pc_out, RAS pointer, count and entries hold. ras_err=0. All other requests are ignored that cycle.
- Next-PC priority when stall=0, evaluated in this order:
  1. ret: next = RAS top; pop.
  2. jmp: next = jmp_tgt. If call=1, also push pc_out+STEP.
  3. br_taken: next = pc_out + STEP + (sign_extend(br_off) << 2).
  4. otherwise: next = pc_out + STEP.
- call without jmp is ignored.
- ret together with jmp and/or br_taken: ret wins. No push occurs.
- Arithmetic: all sums are modulo 2^B; wrap-around is silent. The sign extension is from OFF_W to B bits before the shift.
- Pop on empty: pc_out takes pc_out+STEP (sequential). The RAS is unchanged. ras_err=1 for one cycle.
- Push on full: the oldest entry is overwritten (circular buffer). Count stays at RAS_DEPTH. ras_err=1 for one cycle.
- RAS organisation: circular array with top pointer tp and count cnt.
  - Push: tp <= tp+1 mod RAS_DEPTH; entry[tp+1] <= value; cnt <= min(cnt+1, RAS_DEPTH).
  - Pop: value = entry[tp]; tp <= tp-1 mod RAS_DEPTH; cnt <= cnt-1.
- ras_empty = (cnt==0) and ras_full = (cnt==RAS_DEPTH). Both are derived from registered cnt.
- ras_err is registered: it asserts in the cycle after the offending edge and clears on the next non-error edge.
- Reset mid-operation: returns to the reset state immediately. Any pending push or pop is discarded.

Decomposition:
- Package pc_seq_pkg holds:
  - next-PC select encoding constants: SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET (2 bits)
  - a sign-extend-and-shift function parametrised by OFF_W and B
- Sub-module ras_stack (params B, RAS_DEPTH):
  - inputs: push, pop, push_data
  - outputs: top_data, empty, full, err
  - same clk/rst
- pc_seq_unit contains the priority mux, adders and PC register.

Test Plan:
- Reset with RESET_VEC=0x00400000, then 3 idle cycles -> pc_out 0x00400000, 0x00400004, 0x00400008, 0x0040000C; ras_empty=1.
- pc_out=0x100, br_taken=1, br_off=0xFFFE (-2) -> next pc_out=0x100+4-8=0xFC; br_off=0x0003 -> 0x110.
- pc_out=0x200, jmp=1, call=1, jmp_tgt=0x800 -> pc_out=0x800, ras_empty=0. Two idle cycles later, ret=1 -> pc_out=0x204, ras_empty=1.
- Five nested calls with RAS_DEPTH=4 -> ras_full=1 after the 4th; ras_err pulses after the 5th. Four rets return the 5th, 4th, 3rd and 2nd link addresses. A 5th ret -> sequential PC, ras_err pulse.
- stall=1 held 3 cycles while jmp=1 and ret=1 are asserted -> pc_out and cnt unchanged, ras_err=0. Release stall with ret=1, jmp=1 -> ret wins, popped value loaded.
- pc_out=0xFFFFFFFC idle -> wraps to 0x00000000. Assert rst asynchronously mid-cycle during a push -> pc_out=RESET_VEC before the next edge, cnt=0.
